// File: rtl/inert_pkg.sv
// Shared types and constant tables for the iNEMO inertial-sensor controller.
// Holds the FSM state type, the configuration command list and the read address map.
package inert_pkg;

    typedef enum logic [2:0] {
        StPwrup,
        StCfgIssue,
        StCfgWait,
        StIdle,
        StRdIssue,
        StRdWait
    } state_e;

    localparam int unsigned N_CFG = 4;
    localparam int unsigned CfgIdxW = $clog2(N_CFG);
    localparam logic [15:0] CFG_CMD [N_CFG] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};

    localparam int unsigned N_RD = 10;
    localparam int unsigned IdxW = 4;
    localparam logic [7:0] RD_ADDR [N_RD] = '{
        8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hAA, 8'hAB
    };

    // Byte slot of each register in the read sequence; low byte precedes high byte.
    localparam int unsigned IdxPtchL = 0;
    localparam int unsigned IdxPtchH = 1;
    localparam int unsigned IdxRollL = 2;
    localparam int unsigned IdxRollH = 3;
    localparam int unsigned IdxYawL  = 4;
    localparam int unsigned IdxYawH  = 5;
    localparam int unsigned IdxAxL   = 6;
    localparam int unsigned IdxAxH   = 7;
    localparam int unsigned IdxAyL   = 8;
    localparam int unsigned IdxAyH   = 9;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/inert_intf.sv
// Sequences SPI_mnrch to configure the iNEMO sensor after power-up and, on each
// data-ready interrupt, reads ten byte registers and publishes five 16-bit words.
module inert_intf
    import inert_pkg::*;
#(
    parameter int unsigned INIT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch,
    output logic [15:0] roll,
    output logic [15:0] yaw,
    output logic [15:0] ax,
    output logic [15:0] ay,
    output logic        vld
);

    state_e            state_q, state_d;
    logic [INIT_W-1:0] timer_q, timer_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              wrt_q, wrt_d;
    logic [15:0]       cmd_q, cmd_d;
    logic              vld_q, vld_d;
    logic [7:0]        byte_q [N_RD];
    logic [7:0]        byte_d [N_RD];
    logic [15:0]       ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic [15:0]       ax_q, ax_d, ay_q, ay_d;
    logic              int_s;
    logic              unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    sync2 u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (INT),
        .q     (int_s)
    );

    // wrt and cmd are registered and set on the edge entering an issue state,
    // so wrt lands exactly one clock after the done that triggered it.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        wrt_d   = 1'b0;
        cmd_d   = cmd_q;
        vld_d   = 1'b0;
        byte_d  = byte_q;
        ptch_d  = ptch_q;
        roll_d  = roll_q;
        yaw_d   = yaw_q;
        ax_d    = ax_q;
        ay_d    = ay_q;

        unique case (state_q)
            StPwrup: begin
                timer_d = timer_q + INIT_W'(1);
                if (timer_q == '1) begin
                    state_d = StCfgIssue;
                    wrt_d   = 1'b1;
                    cmd_d   = CFG_CMD[0];
                end
            end
            StCfgIssue: state_d = StCfgWait;
            StCfgWait: begin
                if (done) begin
                    if (idx_q == IdxW'(N_CFG - 1)) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StCfgIssue;
                        wrt_d   = 1'b1;
                        cmd_d   = CFG_CMD[idx_d[CfgIdxW-1:0]];
                    end
                end
            end
            StIdle: begin
                if (int_s) begin
                    idx_d   = '0;
                    state_d = StRdIssue;
                    wrt_d   = 1'b1;
                    cmd_d   = {RD_ADDR[0], 8'h00};
                end
            end
            StRdIssue: state_d = StRdWait;
            StRdWait: begin
                if (done) begin
                    byte_d[idx_q] = rd_data[7:0];
                    if (idx_q == IdxW'(N_RD - 1)) begin
                        // All words update together so no consumer sees a torn set.
                        idx_d   = '0;
                        state_d = StIdle;
                        vld_d   = 1'b1;
                        ptch_d  = {byte_d[IdxPtchH], byte_d[IdxPtchL]};
                        roll_d  = {byte_d[IdxRollH], byte_d[IdxRollL]};
                        yaw_d   = {byte_d[IdxYawH], byte_d[IdxYawL]};
                        ax_d    = {byte_d[IdxAxH], byte_d[IdxAxL]};
                        ay_d    = {byte_d[IdxAyH], byte_d[IdxAyL]};
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StRdIssue;
                        wrt_d   = 1'b1;
                        cmd_d   = {RD_ADDR[idx_d], 8'h00};
                    end
                end
            end
            default: state_d = StPwrup;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPwrup;
            timer_q <= '0;
            idx_q   <= '0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            vld_q   <= 1'b0;
            byte_q  <= '{default: 8'h00};
            ptch_q  <= 16'h0000;
            roll_q  <= 16'h0000;
            yaw_q   <= 16'h0000;
            ax_q    <= 16'h0000;
            ay_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            byte_q  <= byte_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            yaw_q   <= yaw_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
        end
    end

    assign wrt  = wrt_q;
    assign cmd  = cmd_q;
    assign vld  = vld_q;
    assign ptch = ptch_q;
    assign roll = roll_q;
    assign yaw  = yaw_q;
    assign ax   = ax_q;
    assign ay   = ay_q;

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf: a simple SPI responder answers each wrt after a
// fixed latency with bytes from hand-written tables; expectations are hand computed.
module tb_inert_intf;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, vld;
    logic [15:0] cmd, ptch, roll, yaw, ax, ay;

    inert_intf #(.INIT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch    (ptch),
        .roll    (roll),
        .yaw     (yaw),
        .ax      (ax),
        .ay      (ay),
        .vld     (vld)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [15:0] cfg_exp [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
    logic [15:0] rd_exp [10] = '{16'hA200, 16'hA300, 16'hA400, 16'hA500, 16'hA600,
                                 16'hA700, 16'hA800, 16'hA900, 16'hAA00, 16'hAB00};
    logic [7:0]  rd_tbl [3][10];
    logic [15:0] exp_words [3][5];
    int          set_idx = 0;

    logic [15:0] cmd_log [$];
    int          wrt_cyc [$];
    int          done_cyc [$];
    int          vld_cnt = 0;
    int          vld_cyc = 0;
    logic [15:0] resp_cmd;

    function automatic logic [7:0] lookup(input logic [7:0] a);
        if (a >= 8'hA2 && a <= 8'hAB) return rd_tbl[set_idx][a - 8'hA2];
        return 8'h00;
    endfunction

    // SPI responder: done follows wrt by LAT clocks; upper rd_data byte is junk.
    initial begin
        @(negedge clk);
        forever begin
            if (wrt && rst_n) begin
                resp_cmd = cmd;
                cmd_log.push_back(cmd);
                wrt_cyc.push_back(cyc);
                repeat (LAT) @(negedge clk);
                check("cmd_hold", cmd, resp_cmd);
                done = 1'b1;
                rd_data = {8'h5A, lookup(resp_cmd[15:8])};
                done_cyc.push_back(cyc);
                @(negedge clk);
                done = 1'b0;
                rd_data = 16'h0000;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        logic pw, pv;
        pw = 1'b0;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (wrt) check("wrt_gap", pw, 1'b0);
            if (vld) begin
                check("vld_width", pv, 1'b0);
                vld_cnt++;
                vld_cyc = cyc;
            end
            pw = wrt;
            pv = vld;
        end
    end

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        INT = 1'b0;
        #1;
        check("rst_wrt", wrt, 1'b0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_vld", vld, 1'b0);
        check("rst_ptch", ptch, 16'h0000);
        check("rst_ay", ay, 16'h0000);
        repeat (3) @(negedge clk);
        cmd_log.delete();
        wrt_cyc.delete();
        done_cyc.delete();
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!wrt && n < 100);
        check("pwrup_len", n, 16);
        check("cfg0_cmd", cmd, 16'h0D02);
    endtask

    task automatic check_cfg();
        int n = 0;
        while (cmd_log.size() < 4 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (40) @(negedge clk);
        #1;
        check("cfg_count", cmd_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < cmd_log.size()) check("cfg_cmd", cmd_log[i], cfg_exp[i]);
        for (int i = 1; i < 4; i++)
            if (i < wrt_cyc.size() && i <= done_cyc.size())
                check("cfg_gap", wrt_cyc[i], done_cyc[i-1] + 1);
    endtask

    task automatic wait_vld(input int target, input string tag);
        int n = 0;
        while (vld_cnt < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, vld_cnt, target);
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (done_cyc.size() < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_wait", done_cyc.size(), target);
    endtask

    task automatic check_set(input int s, input int base);
        for (int i = 0; i < 10; i++)
            if (base + i < cmd_log.size()) check("rd_cmd", cmd_log[base+i], rd_exp[i]);
        check("ptch", ptch, exp_words[s][0]);
        check("roll", roll, exp_words[s][1]);
        check("yaw", yaw, exp_words[s][2]);
        check("ax", ax, exp_words[s][3]);
        check("ay", ay, exp_words[s][4]);
    endtask

    initial begin
        int base;
        int vc;
        int n;
        rd_tbl[0] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'h11, 8'h22};
        rd_tbl[1] = '{8'h01, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        rd_tbl[2] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'h1E, 8'hAC, 8'hCE, 8'hFA};
        exp_words[0] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h2211};
        exp_words[1] = '{16'h8001, 16'h7FFF, 16'h0000, 16'hAA55, 16'hF00F};
        exp_words[2] = '{16'hBEEF, 16'hDEAD, 16'hF00D, 16'hAC1E, 16'hFACE};
        #2;

        // Power-up wait and configuration list.
        do_reset();
        check_cfg();

        // One interrupt pulse -> one full read set.
        set_idx = 0;
        INT = 1'b1;
        repeat (4) @(negedge clk);
        INT = 1'b0;
        wait_vld(1, "vld_set0");
        check_set(0, 4);

        // Quiet period: nothing moves without INT.
        base = cmd_log.size();
        repeat (5000) @(negedge clk);
        #1;
        check("quiet_wrt", cmd_log.size(), base);
        check("quiet_vld", vld_cnt, 1);
        check("quiet_ptch", ptch, 16'h1234);
        check("quiet_ay", ay, 16'h2211);

        // INT glitches mid-sequence, stays high at end -> back-to-back sets.
        set_idx = 1;
        base = cmd_log.size();
        INT = 1'b1;
        wait_dones(base + 3);
        INT = 1'b0;
        repeat (5) @(negedge clk);
        INT = 1'b1;
        wait_vld(2, "vld_set1");
        vc = vld_cyc;
        set_idx = 2;
        check_set(1, base);
        check("rd_total", cmd_log.size(), base + 10);
        n = 0;
        while (cmd_log.size() <= base + 10 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (wrt_cyc.size() > base + 10) begin
            check("restart_cyc", wrt_cyc[base+10], vc + 1);
            check("restart_cmd", cmd_log[base+10], 16'hA200);
        end else begin
            check("restart_seen", cmd_log.size(), base + 11);
        end
        wait_dones(base + 13);
        INT = 1'b0;
        wait_vld(3, "vld_set2");
        check_set(2, base + 10);
        repeat (50) @(negedge clk);
        #1;
        check("stop_wrt", cmd_log.size(), base + 20);

        // Reset between the 5th done and the 6th wrt.
        set_idx = 0;
        base = cmd_log.size();
        INT = 1'b1;
        wait_dones(done_cyc.size() + 5);
        INT = 1'b0;
        check("pre_rst_wrt", cmd_log.size(), base + 5);
        do_reset();
        check_cfg();
        check("post_rst_vld", vld_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
